hex_value_formatter: RTL and testbench

HEX_VALUE_FORMATTER -- requirements
Module: hex_value_formatter

---
 rtl/hex_value_formatter_pkg.sv | 40 ++++
 rtl/hex_value_formatter_if.sv | 33 +++
 rtl/hex_value_formatter_seg7.sv | 28 ++
 rtl/hex_value_formatter.sv | 125 ++++++++++++
 tb/tb_hex_value_formatter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/hex_value_formatter_pkg.sv
// Shared types and constants for the hex value formatter.
// Segment bytes: bit0=a .. bit6=g, bit7=dp, active-high.
package hex_disp_pkg;

  localparam int DIGITS      = 4;
  localparam int CONV_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    ENCODE = 2'd2
  } state_e;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [31:0] SEG_ALL_DASH = 32'h4040_4040;

  // Double-dabble correction: add 3 to every BCD nibble >= 5.
  function automatic logic [19:0] bcd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_value_formatter_if.sv
// Input handshake and segment output bundle.
// master drives values in, slave is the formatter.
interface hex_value_formatter_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_signed;
  logic [31:0] seg_data;
  logic        seg_valid;
  logic        busy;

  modport master (
    output in_valid,
    output in_data,
    output in_signed,
    input  in_ready,
    input  seg_data,
    input  seg_valid,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_signed,
    output in_ready,
    output seg_data,
    output seg_valid,
    output busy
  );

endinterface

// File: rtl/hex_value_formatter_seg7.sv
// BCD digit to 7-segment byte lookup.
// Non-decimal codes map to blank.
module seg7_encode
  import hex_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  // Pure lookup; dp is never lit here.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_value_formatter.sv
// 16-bit value to 4-digit 7-segment word formatter.
// Serial double-dabble, one bit per cycle, then one encode cycle.
module hex_value_formatter
  import hex_disp_pkg::*;
#(
  parameter bit          LZ_BLANK      = 1'b1,
  parameter logic [31:0] RESET_PATTERN = 32'h0000_003F
) (
  input  logic                 clk,
  input  logic                 reset,
  hex_value_formatter_if.slave bus
);

  localparam logic [4:0] LAST_ITER = 5'(CONV_CYCLES - 1);

  state_e      state;
  logic        sign;
  logic        ovf;
  logic [15:0] mag;
  logic [19:0] bcd;
  logic [4:0]  cnt;
  logic [31:0] seg_q;
  logic        seg_vld_q;

  logic        accept;
  logic        in_neg;
  logic [15:0] in_mag;
  logic        in_ovf;
  logic [35:0] shifted;

  logic [7:0]  seg_raw [DIGITS];
  logic [1:0]  msd;
  logic [1:0]  minus_dig;
  logic [31:0] word;

  assign accept = bus.in_valid && (state == IDLE);

  // Input sign/magnitude split and range check at accept time.
  always_comb begin
    in_neg = bus.in_signed & bus.in_data[15];
    in_mag = in_neg ? (~bus.in_data + 16'd1) : bus.in_data;
    in_ovf = in_neg ? (in_mag > 16'd999) : (in_mag > 16'd9999);
  end

  assign shifted = {bcd_adjust(bcd), mag} << 1;

  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .digit (bcd[4*g +: 4]),
      .seg   (seg_raw[g])
    );
  end

  // Locate the most significant nonzero digit (digit 0 if all zero).
  always_comb begin
    msd = 2'd0;
    if (bcd[7:4]   != 4'd0) msd = 2'd1;
    if (bcd[11:8]  != 4'd0) msd = 2'd2;
    if (bcd[15:12] != 4'd0) msd = 2'd3;
  end

  // Assemble display word: blanking, sign, overflow dashes.
  always_comb begin
    word = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (LZ_BLANK && (2'(i) > msd))
        word[8*i +: 8] = SEG_BLANK;
      else
        word[8*i +: 8] = seg_raw[i];
    end
    minus_dig = LZ_BLANK ? (msd + 2'd1) : 2'd3;
    if (sign)
      word[{minus_dig, 3'b000} +: 8] = SEG_MINUS;
    if (ovf)
      word = SEG_ALL_DASH;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      seg_q     <= RESET_PATTERN;
      seg_vld_q <= 1'b0;
      bcd       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      ovf       <= 1'b0;
      mag       <= '0;
    end else begin
      seg_vld_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            sign  <= in_neg;
            mag   <= in_mag;
            ovf   <= in_ovf;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          bcd <= shifted[35:16];
          mag <= shifted[15:0];
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER)
            state <= ENCODE;
        end
        ENCODE: begin
          seg_q     <= word;
          seg_vld_q <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.seg_data  = seg_q;
  assign bus.seg_valid = seg_vld_q;

endmodule

// File: tb/tb_hex_value_formatter.sv
// Bench for hex_value_formatter: LZ_BLANK=1 and LZ_BLANK=0 DUTs
// share stimulus; a queue holds expected words until seg_valid.
module tb_hex_value_formatter;

  typedef struct {
    logic [15:0] data;
    logic        sgn;
    logic [31:0] exp1;
    logic [31:0] exp0;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp1;
    logic [31:0] exp0;
    string       name;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic [15:0] in_data = '0;

  int   n_cmp = 0;
  int   n_fail = 0;
  sb_t  sbq[$];
  vec_t vecs[17];

  always #5 clk = ~clk;

  hex_value_formatter_if bus1 ();
  hex_value_formatter_if bus0 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.in_signed = in_signed;
  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.in_signed = in_signed;

  hex_value_formatter #(.LZ_BLANK(1'b1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  hex_value_formatter #(.LZ_BLANK(1'b0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  task automatic check32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: pop and compare whenever a result is presented.
  always @(negedge clk) begin
    sb_t e;
    if (!reset && bus1.seg_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_seg_valid: got %h, expected no output",
                 bus1.seg_data);
      end else begin
        e = sbq.pop_front();
        check32({e.name, "_lz1"}, bus1.seg_data, e.exp1);
        check32({e.name, "_lz0"}, bus0.seg_data, e.exp0);
        check_int({e.name, "_valid_lz0"}, int'(bus0.seg_valid), 1);
      end
    end else if (!reset && bus0.seg_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL lone_seg_valid_lz0: got %h, expected no output",
               bus0.seg_data);
    end
  end

  task automatic run_vec(input vec_t v);
    int  k;
    int  lat;
    bit  rdy_seen;
    k = 0;
    while (!bus1.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    in_data   = v.data;
    in_signed = v.sgn;
    in_valid  = 1'b1;
    sbq.push_back('{v.exp1, v.exp0, v.name});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_int({v.name, "_busy"}, int'(bus1.busy), 1);
    lat = -1;
    rdy_seen = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (bus1.seg_valid) begin
        lat = i;
        break;
      end
      if (bus1.in_ready) rdy_seen = 1'b1;
    end
    check_int({v.name, "_latency"}, lat, 17);
    check_int({v.name, "_ready_low"}, int'(rdy_seen), 0);
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    check_int({nm, "_drain"}, sbq.size(), 0);
  endtask

  initial begin
    int acc;
    int vseen;

    vecs = '{
      '{16'd1234, 1'b0, 32'h065B_4F66, 32'h065B_4F66, "u1234"},
      '{16'd7,    1'b0, 32'h0000_0007, 32'h3F3F_3F07, "u7"},
      '{16'd0,    1'b0, 32'h0000_003F, 32'h3F3F_3F3F, "u0"},
      '{16'hFFD6, 1'b1, 32'h0040_665B, 32'h403F_665B, "s_m42"},
      '{16'd10000,1'b0, 32'h4040_4040, 32'h4040_4040, "u10000"},
      '{16'hFC18, 1'b1, 32'h4040_4040, 32'h4040_4040, "s_m1000"},
      '{16'h8000, 1'b1, 32'h4040_4040, 32'h4040_4040, "s_m32768"},
      '{16'd9999, 1'b0, 32'h6F6F_6F6F, 32'h6F6F_6F6F, "u9999"},
      '{16'hFC19, 1'b1, 32'h406F_6F6F, 32'h406F_6F6F, "s_m999"},
      '{16'hFFD6, 1'b0, 32'h4040_4040, 32'h4040_4040, "u65494"},
      '{16'd5,    1'b1, 32'h0000_006D, 32'h3F3F_3F6D, "s5"},
      '{16'hFFFF, 1'b1, 32'h0000_4006, 32'h403F_3F06, "s_m1"},
      '{16'd100,  1'b0, 32'h0006_3F3F, 32'h3F06_3F3F, "u100"},
      '{16'd1000, 1'b0, 32'h063F_3F3F, 32'h063F_3F3F, "u1000"},
      '{16'hFF9C, 1'b1, 32'h4006_3F3F, 32'h4006_3F3F, "s_m100"},
      '{16'h7FFF, 1'b1, 32'h4040_4040, 32'h4040_4040, "s32767"},
      '{16'd1234, 1'b1, 32'h065B_4F66, 32'h065B_4F66, "s1234"}
    };

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check32("rst_hold_seg_lz1", bus1.seg_data, 32'h0000_003F);
    check32("rst_hold_seg_lz0", bus0.seg_data, 32'h0000_003F);
    reset = 1'b0;
    #1;
    check_int("rst_ready", int'(bus1.in_ready), 1);
    check_int("rst_busy", int'(bus1.busy), 0);
    check_int("rst_valid", int'(bus1.seg_valid), 0);

    // Table-driven vectors.
    foreach (vecs[i]) run_vec(vecs[i]);
    wait_drain("table");

    // Back-to-back with in_valid held high.
    @(negedge clk);
    in_data   = 16'd1;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    sbq.push_back('{32'h0000_0006, 32'h3F3F_3F06, "b2b_1"});
    @(posedge clk);
    #1;
    in_data = 16'd2;
    acc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus1.in_ready) begin
        acc = k;
        sbq.push_back('{32'h0000_005B, 32'h3F3F_3F5B, "b2b_2"});
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_int("b2b_second_accept_edge", acc, 18);
    wait_drain("b2b");

    // Reset in the middle of a conversion.
    @(negedge clk);
    in_data   = 16'd1234;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_int("abort_busy_before", int'(bus1.busy), 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check32("abort_seg_lz1", bus1.seg_data, 32'h0000_003F);
    check32("abort_seg_lz0", bus0.seg_data, 32'h0000_003F);
    check_int("abort_ready", int'(bus1.in_ready), 1);
    check_int("abort_busy", int'(bus1.busy), 0);
    vseen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus1.seg_valid || bus0.seg_valid) vseen++;
    end
    check_int("abort_no_seg_valid", vseen, 0);
    check32("abort_seg_hold", bus1.seg_data, 32'h0000_003F);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
